mem_access_unit: RTL

Load/store sequencer between the RV32I multicycle control path and the 1024x32 word BRAM.
- Converts a byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW request into active-low word-memory strobes.
- Extracts and sign- or zero-extends load data.
- Performs read-modify-write for SB/SH, because the memory writes whole words only.
- Memory samples on negedge; this block is posedge-only.

---
 rtl/mem_access_unit_if.sv | 30 +++
 rtl/mem_access_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Request-side and memory-side signal bundle of the load/store sequencer.
// The slave modport is the sequencer; the master side is control path plus BRAM.
interface mem_access_unit_if #(
  parameter int WORDS = 10
);
  logic             req_i;
  logic             we_i;
  logic [2:0]       funct3_i;
  logic [31:0]      byte_addr_i;
  logic [31:0]      wdata_i;
  logic             ready_o;
  logic             done_o;
  logic             err_o;
  logic [31:0]      rdata_o;
  logic [WORDS-1:0] mem_addr_o;
  logic [31:0]      mem_data_o;
  logic             mem_wr_no;
  logic             mem_rd_no;
  logic [31:0]      mem_data_i;

  modport slave (
    input  req_i, we_i, funct3_i, byte_addr_i, wdata_i, mem_data_i,
    output ready_o, done_o, err_o, rdata_o, mem_addr_o, mem_data_o, mem_wr_no, mem_rd_no
  );

  modport master (
    output req_i, we_i, funct3_i, byte_addr_i, wdata_i, mem_data_i,
    input  ready_o, done_o, err_o, rdata_o, mem_addr_o, mem_data_o, mem_wr_no, mem_rd_no
  );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I load/store sequencer for a word-wide BRAM that samples on negedge.
// Byte and half stores become a read-modify-write of the containing word.
module mem_access_unit #(
  parameter int WORDS      = 10,
  parameter int DATA_WIDTH = 32
) (
  input logic              clk_i,
  input logic              reset_ni,
  mem_access_unit_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]            state_r;
  logic [1:0]            state_s;
  logic                  we_r;
  logic [2:0]            f3_r;
  logic [1:0]            off_r;
  logic [15:0]           wdata_r;
  logic                  ready_r;
  logic                  done_r;
  logic                  err_r;
  logic                  rd_n_r;
  logic                  wr_n_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [DATA_WIDTH-1:0] mem_data_r;
  logic [WORDS-1:0]      addr_r;
  logic                  accept_s;
  logic                  illegal_s;
  logic                  is_sw_s;
  logic                  unused_s;

  function automatic logic access_illegal(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic bad_f3;
    logic misaligned;
    if (we) begin
      bad_f3 = !((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010));
    end else begin
      bad_f3 = (f3 == 3'b011) || (f3[2:1] == 2'b11);
    end
    misaligned = ((f3[1:0] == 2'b01) && off[0]) || ((f3 == 3'b010) && (off != 2'b00));
    return bad_f3 || misaligned;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_extract(input logic [DATA_WIDTH-1:0] w,
                                                         input logic [2:0] f3, input logic [1:0] off);
    logic [7:0]            b;
    logic [15:0]           h;
    logic [DATA_WIDTH-1:0] r;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h000000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // SB replaces one byte lane, SH one half; funct3[0] tells them apart.
  function automatic logic [DATA_WIDTH-1:0] store_merge(input logic [DATA_WIDTH-1:0] w, input logic [15:0] wd,
                                                        input logic [2:0] f3, input logic [1:0] off);
    logic [DATA_WIDTH-1:0] r;
    r = w;
    if (f3[0] == 1'b0) begin
      r[{off, 3'b000} +: 8] = wd[7:0];
    end else begin
      r[{off[1], 4'b0000} +: 16] = wd;
    end
    return r;
  endfunction

  assign accept_s  = (state_r == IDLE) && bus.req_i;
  assign illegal_s = access_illegal(bus.we_i, bus.funct3_i, bus.byte_addr_i[1:0]);
  assign is_sw_s   = bus.we_i && (bus.funct3_i == 3'b010);
  assign unused_s  = ^{bus.byte_addr_i[31:WORDS+2]};

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!bus.req_i)     state_s = IDLE;
        else if (illegal_s) state_s = DONE;
        else if (is_sw_s)   state_s = WRITE;
        else                state_s = READ;
      end
      READ: begin
        if (we_r) state_s = WRITE;
        else      state_s = DONE;
      end
      WRITE:   state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State and handshake/strobe flops, all loaded from the next-state value so outputs are glitch-free.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      rd_n_r  <= 1'b1;
      wr_n_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == IDLE);
      done_r  <= (state_s == DONE);
      err_r   <= accept_s && illegal_s;
      rd_n_r  <= (state_s != READ);
      wr_n_r  <= (state_s != WRITE);
    end
  end

  // Request capture, load result and write-data datapath.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      we_r       <= 1'b0;
      f3_r       <= 3'b000;
      off_r      <= 2'b00;
      wdata_r    <= 16'h0000;
      addr_r     <= '0;
      rdata_r    <= '0;
      mem_data_r <= '0;
    end else begin
      if (accept_s) begin
        we_r    <= bus.we_i;
        f3_r    <= bus.funct3_i;
        off_r   <= bus.byte_addr_i[1:0];
        wdata_r <= bus.wdata_i[15:0];
        addr_r  <= bus.byte_addr_i[WORDS+1:2];
      end
      // Write data is set up one edge ahead of WRITE so it is stable at the memory negedge.
      if (accept_s && !illegal_s && is_sw_s) begin
        mem_data_r <= bus.wdata_i;
      end else if ((state_r == READ) && we_r) begin
        mem_data_r <= store_merge(bus.mem_data_i, wdata_r, f3_r, off_r);
      end else begin
        mem_data_r <= mem_data_r;
      end
      if ((state_r == READ) && !we_r) begin
        rdata_r <= load_extract(bus.mem_data_i, f3_r, off_r);
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  assign bus.ready_o    = ready_r;
  assign bus.done_o     = done_r;
  assign bus.err_o      = err_r;
  assign bus.rdata_o    = rdata_r;
  assign bus.mem_addr_o = addr_r;
  assign bus.mem_data_o = mem_data_r;
  assign bus.mem_rd_no  = rd_n_r;
  assign bus.mem_wr_no  = wr_n_r;
endmodule
